// File: rtl/mul_div_unit_if.sv
// ============================================================================
//  Module   : mul_div_unit_if
//  Purpose  : Operation handshake and result bus between control unit and the
//             multi-cycle signed multiply/divide engine.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface mul_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] Zhigh;
    logic [WIDTH-1:0] Zlow;

    modport master (
        output start, op, a_in, b_in,
        input  busy, done, div_by_zero, Zhigh, Zlow
    );

    modport slave (
        input  start, op, a_in, b_in,
        output busy, done, div_by_zero, Zhigh, Zlow
    );
endinterface

`default_nettype wire

// File: rtl/mul_div_unit.sv
// ============================================================================
//  Module   : mul_div_unit
//  Purpose  : Multi-cycle signed multiply (radix-2 Booth) / divide (restoring)
//             producing a 2*WIDTH result into the Zhigh/Zlow register pair.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  wire logic       clock,
    input  wire logic       clear,
    mul_div_unit_if.slave   bus
);

    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] C_IDLE   = 2'd0;
    localparam logic [1:0] C_RUN    = 2'd1;
    localparam logic [1:0] C_FINISH = 2'd2;
    localparam logic [1:0] C_DONE   = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic             qm1_q, qm1_d;
    logic             op_q, op_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] zhi_q, zhi_d;
    logic [WIDTH-1:0] zlo_q, zlo_d;
    logic             dbz_q, dbz_d;

    logic             accept;
    logic             busy_w;
    logic             done_w;
    logic             last_iter;
    logic [WIDTH:0]   m_ext;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_t;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    assign last_iter = (cnt_q == CW'(WIDTH - 1));

    // ------------------------------------------------------------------ state
    always_ff @(posedge clock) begin
        if (!clear) begin
            state_q <= C_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A divide by zero still spends one RUN cycle (no iteration) so that its
    // result lands two edges after the accept edge.
    always_comb begin
        state_d = state_q;
        case (state_q)
            C_IDLE:   state_d = accept ? C_RUN : C_IDLE;
            C_RUN:    state_d = (dz_q || last_iter) ? C_FINISH : C_RUN;
            C_FINISH: state_d = C_DONE;
            C_DONE:   state_d = accept ? C_RUN : C_IDLE;
            default:  state_d = C_IDLE;
        endcase
    end

    always_comb begin
        busy_w = 1'b0;
        done_w = 1'b0;
        accept = 1'b0;
        case (state_q)
            C_IDLE:   accept = bus.start;
            C_RUN:    busy_w = 1'b1;
            C_FINISH: busy_w = 1'b1;
            C_DONE: begin
                done_w = 1'b1;
                accept = bus.start;
            end
            default: ;
        endcase
    end

    // --------------------------------------------------------------- datapath
    always_comb begin
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        lo_d   = lo_q;
        m_d    = m_q;
        qm1_d  = qm1_q;
        op_d   = op_q;
        qneg_d = qneg_q;
        rneg_d = rneg_q;
        dz_d   = dz_q;
        zhi_d  = zhi_q;
        zlo_d  = zlo_q;
        dbz_d  = dbz_q;
        a_mag  = bus.a_in[WIDTH-1] ? -bus.a_in : bus.a_in;
        b_mag  = bus.b_in[WIDTH-1] ? -bus.b_in : bus.b_in;
        // Acc carries one guard bit so the most negative multiplicand can be
        // subtracted without overflowing the partial product.
        m_ext  = {m_q[WIDTH-1], m_q};
        sum    = acc_q;
        rem_t  = {acc_q[WIDTH-1:0], lo_q[WIDTH-1]};
        diff   = rem_t[WIDTH-1:0] - m_q;

        if (accept) begin
            cnt_d  = '0;
            qm1_d  = 1'b0;
            op_d   = bus.op;
            dbz_d  = 1'b0;
            qneg_d = bus.a_in[WIDTH-1] ^ bus.b_in[WIDTH-1];
            rneg_d = bus.a_in[WIDTH-1];
            if (!bus.op) begin
                acc_d = '0;
                lo_d  = bus.b_in;
                m_d   = bus.a_in;
                dz_d  = 1'b0;
            end else begin
                dz_d  = (bus.b_in == '0);
                acc_d = (bus.b_in == '0) ? {bus.a_in[WIDTH-1], bus.a_in} : '0;
                lo_d  = a_mag;
                m_d   = b_mag;
            end
        end else if (state_q == C_RUN && !dz_q) begin
            cnt_d = cnt_q + CW'(1);
            if (!op_q) begin
                case ({lo_q[0], qm1_q})
                    2'b01:   sum = acc_q + m_ext;
                    2'b10:   sum = acc_q - m_ext;
                    default: sum = acc_q;
                endcase
                acc_d = {sum[WIDTH], sum[WIDTH:1]};
                lo_d  = {sum[0], lo_q[WIDTH-1:1]};
                qm1_d = lo_q[0];
            end else if (rem_t >= {1'b0, m_q}) begin
                acc_d = {1'b0, diff};
                lo_d  = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_d = {1'b0, rem_t[WIDTH-1:0]};
                lo_d  = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else if (state_q == C_FINISH) begin
            if (dz_q) begin
                zhi_d = acc_q[WIDTH-1:0];
                zlo_d = '1;
                dbz_d = 1'b1;
            end else if (op_q) begin
                zhi_d = rneg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                zlo_d = qneg_q ? -lo_q : lo_q;
            end else begin
                zhi_d = acc_q[WIDTH-1:0];
                zlo_d = lo_q;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!clear) begin
            cnt_q  <= '0;
            acc_q  <= '0;
            lo_q   <= '0;
            m_q    <= '0;
            qm1_q  <= 1'b0;
            op_q   <= 1'b0;
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
            dz_q   <= 1'b0;
            zhi_q  <= '0;
            zlo_q  <= '0;
            dbz_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            lo_q   <= lo_d;
            m_q    <= m_d;
            qm1_q  <= qm1_d;
            op_q   <= op_d;
            qneg_q <= qneg_d;
            rneg_q <= rneg_d;
            dz_q   <= dz_d;
            zhi_q  <= zhi_d;
            zlo_q  <= zlo_d;
            dbz_q  <= dbz_d;
        end
    end

    assign bus.busy        = busy_w;
    assign bus.done        = done_w;
    assign bus.div_by_zero = dbz_q;
    assign bus.Zhigh       = zhi_q;
    assign bus.Zlow        = zlo_q;

endmodule

`default_nettype wire

// File: tb/tb_mul_div_unit.sv
// ============================================================================
//  Module   : tb_mul_div_unit
//  Purpose  : Scoreboard bench for mul_div_unit against an arithmetic model.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mul_div_unit;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          t;
        int          brun;
    } exp_t;

    logic clk;
    logic clear;
    int   cyc;
    int   total;
    int   bad;
    int   ndone;
    int   brun;
    exp_t sb[$];

    mul_div_unit_if #(.WIDTH(32)) bus ();

    mul_div_unit #(.WIDTH(32)) dut (
        .clock (clk),
        .clear (clear),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic exp_t model(input bit op, input logic [31:0] a, input logic [31:0] b,
                                   input int t0);
        exp_t   e;
        longint sa;
        longint sbv;
        longint p;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        e.dz = 1'b0;
        if (!op) begin
            p    = sa * sbv;
            e.hi = p[63:32];
            e.lo = p[31:0];
            e.t  = t0 + 33;
            e.brun = 33;
        end else if (b == 32'd0) begin
            e.hi = a;
            e.lo = 32'hFFFF_FFFF;
            e.dz = 1'b1;
            e.t  = t0 + 2;
            e.brun = 2;
        end else begin
            p    = sa / sbv;
            e.lo = p[31:0];
            p    = sa % sbv;
            e.hi = p[31:0];
            e.t  = t0 + 33;
            e.brun = 33;
        end
        return e;
    endfunction

    // Monitor: compare every done pulse against the oldest expectation.
    always begin
        @(posedge clk);
        #1;
        if (bus.done === 1'b1) begin
            ndone++;
            if (sb.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_edge",  64'(cyc),    64'(e.t));
                chk("Zhigh",      64'(bus.Zhigh), 64'(e.hi));
                chk("Zlow",       64'(bus.Zlow),  64'(e.lo));
                chk("div_by_zero", 64'(bus.div_by_zero), 64'(e.dz));
                chk("busy_cycles", 64'(brun),  64'(e.brun));
            end
        end
        if (bus.busy === 1'b1) brun++;
        else brun = 0;
    end

    // Called at posedge+1: drive start, wait for the accept edge, record expectation.
    task automatic issue(input bit op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a_in  = a;
        bus.b_in  = b;
        @(posedge clk);
        #1;
        sb.push_back(model(op, a, b, cyc));
        bus.start = 1'b0;
        bus.a_in  = $urandom;
        bus.b_in  = $urandom;
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) seen = 1'b1;
        end
        if (!seen) chk("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int nd0;
        cyc   = 0;
        total = 0;
        bad   = 0;
        ndone = 0;
        brun  = 0;
        clear = 1'b0;
        bus.start = 1'b1;
        bus.op    = 1'b0;
        bus.a_in  = 32'd5;
        bus.b_in  = 32'd9;

        // Reset held with start asserted
        idle(2);
        chk("rst_busy",  64'(bus.busy),  64'd0);
        chk("rst_done",  64'(bus.done),  64'd0);
        chk("rst_Zhigh", 64'(bus.Zhigh), 64'd0);
        chk("rst_Zlow",  64'(bus.Zlow),  64'd0);
        chk("rst_dbz",   64'(bus.div_by_zero), 64'd0);
        clear     = 1'b1;
        bus.start = 1'b0;
        idle(3);
        chk("no_op_after_rst", 64'(bus.busy), 64'd0);

        // Directed multiplies, then back-to-back divide from DONE
        issue(1'b0, 32'd7, 32'hFFFF_FFFD);
        wait_done();
        idle(2);
        issue(1'b0, 32'h8000_0000, 32'h8000_0000);
        wait_done();
        issue(1'b1, -32'sd17, 32'd5);
        wait_done();
        idle(1);

        // Divide by zero, then most-negative / -1
        issue(1'b1, 32'd100, 32'd0);
        wait_done();
        idle(1);
        issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("dbz_clear_on_accept", 64'(bus.div_by_zero), 64'd0);
        wait_done();
        idle(1);

        // Start re-pulsed while running must be ignored
        nd0 = ndone;
        issue(1'b0, 32'h1234_5678, 32'hFEDC_BA98);
        idle(9);
        bus.start = 1'b1;
        bus.op    = 1'b1;
        bus.a_in  = 32'd77;
        bus.b_in  = 32'd0;
        idle(1);
        bus.start = 1'b0;
        idle(40);
        chk("single_done", 64'(ndone - nd0), 64'd1);

        // Clear mid-operation discards the result
        nd0 = ndone;
        issue(1'b0, 32'd1000, 32'd3000);
        idle(19);
        sb.delete();
        clear = 1'b0;
        idle(1);
        chk("abort_busy",  64'(bus.busy),  64'd0);
        chk("abort_Zhigh", 64'(bus.Zhigh), 64'd0);
        chk("abort_Zlow",  64'(bus.Zlow),  64'd0);
        clear = 1'b1;
        idle(40);
        chk("abort_no_done", 64'(ndone - nd0), 64'd0);
        issue(1'b1, 32'd6, 32'd3);
        wait_done();

        // Randomized mix, including corner operands and back-to-back starts
        for (int i = 0; i < 60; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            bit          op;
            op = 1'($urandom);
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: a = 32'h8000_0000;
                2: b = 32'hFFFF_FFFF;
                3: b = 32'($urandom_range(1, 20));
                4: a = 32'($signed(-$urandom_range(0, 1000)));
                default: ;
            endcase
            issue(op, a, b);
            wait_done();
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
        end

        idle(5);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
